// File: rtl/conv2d_mem_arbiter.sv
// conv2d_mem_arbiter: shares one IO-DMem request/response port between two
// requesters (0 = conv2D accelerator, 1 = second bus master).
// Reads are granted round-robin per beat. Writes are granted round-robin per
// transaction and held until both the address and data handshakes complete.
// Responses are steered back in issue order by 1-bit owner ID FIFOs.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_rd_addr*/s_rd_data*         requester read channels (packed x2)
//   s_wr_addr*/s_wr_data*/s_wr_resp*  requester write channels (packed x2)
//   m_rd_addr*/m_rd_data*         downstream read channels
//   m_wr_addr*/m_wr_data*/m_wr_resp*  downstream write channels

// Owner ID FIFO: 2^LOGDEPTH entries of 1 bit; a push is refused while full
// even if a pop happens in the same cycle.
module conv2d_mem_arbiter_id_fifo #(
    parameter int unsigned LOGDEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int unsigned DEPTH = 1 << LOGDEPTH;
    localparam int unsigned CW    = LOGDEPTH + 1;

    logic [DEPTH-1:0]    mem;
    logic [LOGDEPTH-1:0] wr_ptr;
    logic [LOGDEPTH-1:0] rd_ptr;
    logic [CW-1:0]       count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module conv2d_mem_arbiter #(
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned LOGDEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*AWIDTH-1:0] s_rd_addr,
    input  logic [1:0]          s_rd_addr_valid,
    output logic [1:0]          s_rd_addr_ready,
    output logic [DWIDTH-1:0]   s_rd_data,
    output logic [1:0]          s_rd_data_valid,
    input  logic [2*AWIDTH-1:0] s_wr_addr,
    input  logic [2*DWIDTH-1:0] s_wr_data,
    input  logic [1:0]          s_wr_addr_valid,
    input  logic [1:0]          s_wr_data_valid,
    output logic [1:0]          s_wr_addr_ready,
    output logic [1:0]          s_wr_data_ready,
    output logic                s_wr_resp,
    output logic [1:0]          s_wr_resp_valid,
    output logic [AWIDTH-1:0]   m_rd_addr,
    output logic                m_rd_addr_valid,
    input  logic                m_rd_addr_ready,
    input  logic [DWIDTH-1:0]   m_rd_data,
    input  logic                m_rd_data_valid,
    output logic [AWIDTH-1:0]   m_wr_addr,
    output logic                m_wr_addr_valid,
    input  logic                m_wr_addr_ready,
    output logic [DWIDTH-1:0]   m_wr_data,
    output logic                m_wr_data_valid,
    input  logic                m_wr_data_ready,
    input  logic                m_wr_resp,
    input  logic                m_wr_resp_valid
);
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_BUSY = 1'b1
    } wr_state_e;

    // ---------------- read path ----------------
    logic rd_last;
    logic rd_grant;
    logic rd_accept;
    logic rd_fire;
    logic rd_ret;
    logic rd_full;
    logic rd_empty;
    logic rd_head;

    // Prefer the requester that did not win last; fall back to the other.
    assign rd_grant  = s_rd_addr_valid[~rd_last] ? ~rd_last : rd_last;
    assign m_rd_addr = rd_grant ? s_rd_addr[2*AWIDTH-1:AWIDTH] : s_rd_addr[AWIDTH-1:0];
    assign m_rd_addr_valid = ~rst & (|s_rd_addr_valid) & ~rd_full;
    assign rd_accept = ~rst & m_rd_addr_ready & ~rd_full;
    assign s_rd_addr_ready = rd_grant ? {rd_accept, 1'b0} : {1'b0, rd_accept};
    assign rd_fire   = m_rd_addr_valid & m_rd_addr_ready;

    // Responses with no outstanding ID are dropped.
    assign s_rd_data       = m_rd_data;
    assign rd_ret          = ~rst & m_rd_data_valid & ~rd_empty;
    assign s_rd_data_valid = rd_head ? {rd_ret, 1'b0} : {1'b0, rd_ret};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_last <= 1'b1;
        end else if (rd_fire) begin
            rd_last <= rd_grant;
        end
    end

    conv2d_mem_arbiter_id_fifo #(.LOGDEPTH(LOGDEPTH)) u_rd_id (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_fire),
        .pop   (m_rd_data_valid),
        .din   (rd_grant),
        .dout  (rd_head),
        .full  (rd_full),
        .empty (rd_empty)
    );

    // ---------------- write path ----------------
    wr_state_e wr_state;
    wr_state_e wr_state_next;
    logic      wr_last;
    logic      wr_last_next;
    logic      wr_owner;
    logic      wr_owner_next;
    logic      aw_done;
    logic      aw_done_next;
    logic      w_done;
    logic      w_done_next;
    logic      wr_grant;
    logic      wr_push;
    logic      aw_fire;
    logic      w_fire;
    logic      wr_full;
    logic      wr_empty;
    logic      wr_head;
    logic      wr_ret;

    assign wr_grant  = s_wr_addr_valid[~wr_last] ? ~wr_last : wr_last;
    assign m_wr_addr = wr_owner ? s_wr_addr[2*AWIDTH-1:AWIDTH] : s_wr_addr[AWIDTH-1:0];
    assign m_wr_data = wr_owner ? s_wr_data[2*DWIDTH-1:DWIDTH] : s_wr_data[DWIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_last  <= 1'b1;
            wr_owner <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_state_next;
            wr_last  <= wr_last_next;
            wr_owner <= wr_owner_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
        end
    end

    // Write FSM: grant in IDLE, then hold the owner until address and data
    // have both been accepted (in either order, or together).
    always_comb begin
        wr_state_next   = wr_state;
        wr_last_next    = wr_last;
        wr_owner_next   = wr_owner;
        aw_done_next    = aw_done;
        w_done_next     = w_done;
        wr_push         = 1'b0;
        aw_fire         = 1'b0;
        w_fire          = 1'b0;
        m_wr_addr_valid = 1'b0;
        m_wr_data_valid = 1'b0;
        s_wr_addr_ready = 2'b00;
        s_wr_data_ready = 2'b00;

        case (wr_state)
            WR_IDLE: begin
                if ((|s_wr_addr_valid) && !wr_full) begin
                    wr_owner_next = wr_grant;
                    aw_done_next  = 1'b0;
                    w_done_next   = 1'b0;
                    wr_state_next = WR_BUSY;
                end
            end
            WR_BUSY: begin
                m_wr_addr_valid = s_wr_addr_valid[wr_owner] & ~aw_done;
                m_wr_data_valid = s_wr_data_valid[wr_owner] & ~w_done;
                // Ready is withheld once a half is done so the owner cannot
                // see a phantom second acceptance.
                s_wr_addr_ready[wr_owner] = m_wr_addr_ready & ~aw_done;
                s_wr_data_ready[wr_owner] = m_wr_data_ready & ~w_done;
                aw_fire      = m_wr_addr_valid & m_wr_addr_ready;
                w_fire       = m_wr_data_valid & m_wr_data_ready;
                aw_done_next = aw_done | aw_fire;
                w_done_next  = w_done | w_fire;
                if (aw_done_next && w_done_next) begin
                    wr_push       = 1'b1;
                    wr_last_next  = wr_owner;
                    wr_state_next = WR_IDLE;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase

        if (rst) begin
            wr_push         = 1'b0;
            m_wr_addr_valid = 1'b0;
            m_wr_data_valid = 1'b0;
            s_wr_addr_ready = 2'b00;
            s_wr_data_ready = 2'b00;
        end
    end

    assign s_wr_resp       = m_wr_resp;
    assign wr_ret          = ~rst & m_wr_resp_valid & ~wr_empty;
    assign s_wr_resp_valid = wr_head ? {wr_ret, 1'b0} : {1'b0, wr_ret};

    conv2d_mem_arbiter_id_fifo #(.LOGDEPTH(LOGDEPTH)) u_wr_id (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_push),
        .pop   (m_wr_resp_valid),
        .din   (wr_owner),
        .dout  (wr_head),
        .full  (wr_full),
        .empty (wr_empty)
    );
endmodule

// File: tb/tb_conv2d_mem_arbiter.sv
// Self-checking bench for conv2d_mem_arbiter: directed scenarios followed by
// randomized read and write traffic checked against a transaction-level model.
module tb_conv2d_mem_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LD    = 3;
    localparam int unsigned DEPTH = 1 << LD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2*AW-1:0] s_rd_addr;
    logic [1:0]      s_rd_addr_valid;
    logic [1:0]      s_rd_addr_ready;
    logic [DW-1:0]   s_rd_data;
    logic [1:0]      s_rd_data_valid;
    logic [2*AW-1:0] s_wr_addr;
    logic [2*DW-1:0] s_wr_data;
    logic [1:0]      s_wr_addr_valid;
    logic [1:0]      s_wr_data_valid;
    logic [1:0]      s_wr_addr_ready;
    logic [1:0]      s_wr_data_ready;
    logic            s_wr_resp;
    logic [1:0]      s_wr_resp_valid;
    logic [AW-1:0]   m_rd_addr;
    logic            m_rd_addr_valid;
    logic            m_rd_addr_ready;
    logic [DW-1:0]   m_rd_data;
    logic            m_rd_data_valid;
    logic [AW-1:0]   m_wr_addr;
    logic            m_wr_addr_valid;
    logic            m_wr_addr_ready;
    logic [DW-1:0]   m_wr_data;
    logic            m_wr_data_valid;
    logic            m_wr_data_ready;
    logic            m_wr_resp;
    logic            m_wr_resp_valid;

    conv2d_mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LOGDEPTH(LD)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_rd_addr       (s_rd_addr),
        .s_rd_addr_valid (s_rd_addr_valid),
        .s_rd_addr_ready (s_rd_addr_ready),
        .s_rd_data       (s_rd_data),
        .s_rd_data_valid (s_rd_data_valid),
        .s_wr_addr       (s_wr_addr),
        .s_wr_data       (s_wr_data),
        .s_wr_addr_valid (s_wr_addr_valid),
        .s_wr_data_valid (s_wr_data_valid),
        .s_wr_addr_ready (s_wr_addr_ready),
        .s_wr_data_ready (s_wr_data_ready),
        .s_wr_resp       (s_wr_resp),
        .s_wr_resp_valid (s_wr_resp_valid),
        .m_rd_addr       (m_rd_addr),
        .m_rd_addr_valid (m_rd_addr_valid),
        .m_rd_addr_ready (m_rd_addr_ready),
        .m_rd_data       (m_rd_data),
        .m_rd_data_valid (m_rd_data_valid),
        .m_wr_addr       (m_wr_addr),
        .m_wr_addr_valid (m_wr_addr_valid),
        .m_wr_addr_ready (m_wr_addr_ready),
        .m_wr_data       (m_wr_data),
        .m_wr_data_valid (m_wr_data_valid),
        .m_wr_data_ready (m_wr_data_ready),
        .m_wr_resp       (m_wr_resp),
        .m_wr_resp_valid (m_wr_resp_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every valid/ready output, packed for one-shot comparisons.
    function automatic logic [12:0] ctl();
        return {s_rd_addr_ready, s_rd_data_valid, s_wr_addr_ready, s_wr_data_ready,
                s_wr_resp_valid, m_rd_addr_valid, m_wr_addr_valid, m_wr_data_valid};
    endfunction

    function automatic logic [5:0] wctl();
        return {m_wr_addr_valid, m_wr_data_valid, s_wr_addr_ready, s_wr_data_ready};
    endfunction

    task automatic idle_inputs();
        s_rd_addr       = '0;
        s_rd_addr_valid = 2'b00;
        s_wr_addr       = '0;
        s_wr_data       = '0;
        s_wr_addr_valid = 2'b00;
        s_wr_data_valid = 2'b00;
        m_rd_addr_ready = 1'b0;
        m_rd_data       = '0;
        m_rd_data_valid = 1'b0;
        m_wr_addr_ready = 1'b0;
        m_wr_data_ready = 1'b0;
        m_wr_resp       = 1'b0;
        m_wr_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state
    int        rlast;
    int        rq[$];
    int        wlast;
    int        wq[$];
    int        wo;
    bit        aw_d;
    bit        w_d;

    initial begin
        int        g;
        int        sz0;
        logic [1:0] rv;
        logic [1:0] e_rdy;
        logic [1:0] e_ret;
        logic       e_mv;
        logic       mrdy;
        logic       mdv;
        logic [1:0] wav;
        logic [1:0] wdv;
        logic       mar;
        logic       mdr;
        logic       rspv;
        logic       e_av;
        logic       e_dv;
        logic [1:0] e_ar;
        logic [1:0] e_dr;
        logic [1:0] e_rs;

        // ---- reset holds every valid/ready low even with inputs active ----
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        s_rd_addr_valid = 2'b11;
        s_wr_addr_valid = 2'b11;
        s_wr_data_valid = 2'b11;
        m_rd_addr_ready = 1'b1;
        m_wr_addr_ready = 1'b1;
        m_wr_data_ready = 1'b1;
        m_rd_data_valid = 1'b1;
        m_wr_resp_valid = 1'b1;
        #1 chk("reset_ctl", 64'(ctl()), 64'h0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // ---- single read ----
        s_rd_addr       = {32'h0, 32'h100};
        s_rd_addr_valid = 2'b01;
        m_rd_addr_ready = 1'b1;
        #1 chk("rd1_addr", 64'(m_rd_addr), 64'h100);
        chk("rd1_vr", 64'({m_rd_addr_valid, s_rd_addr_ready}), 64'b101);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        m_rd_data       = 32'hDEAD;
        m_rd_data_valid = 1'b1;
        #1 chk("rd1_ret_v", 64'(s_rd_data_valid), 64'b01);
        chk("rd1_ret_d", 64'(s_rd_data), 64'hDEAD);
        @(negedge clk);
        #1 chk("rd1_drop_empty", 64'(s_rd_data_valid), 64'b00);
        idle_inputs();

        // ---- read contention: grants alternate 0,1,0,1 ----
        do_reset();
        s_rd_addr       = {32'hB0, 32'hA0};
        s_rd_addr_valid = 2'b11;
        m_rd_addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rdc_addr", 64'(m_rd_addr), (i % 2) ? 64'hB0 : 64'hA0);
            chk("rdc_rdy", 64'(s_rd_addr_ready), (i % 2) ? 64'b10 : 64'b01);
            @(negedge clk);
        end
        idle_inputs();
        m_rd_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_rd_data = 32'(i + 32'h50);
            #1 chk("rdc_ret", 64'(s_rd_data_valid), (i % 2) ? 64'b10 : 64'b01);
            @(negedge clk);
        end
        idle_inputs();

        // ---- read ID FIFO full ----
        do_reset();
        s_rd_addr       = {32'h0, 32'h400};
        s_rd_addr_valid = 2'b01;
        m_rd_addr_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            #1 chk("rdf_fill", 64'({m_rd_addr_valid, s_rd_addr_ready}), 64'b101);
            @(negedge clk);
        end
        #1 chk("rdf_stall", 64'({m_rd_addr_valid, s_rd_addr_ready}), 64'b000);
        @(negedge clk);
        m_rd_data_valid = 1'b1;
        #1 chk("rdf_pop_stall", 64'({m_rd_addr_valid, s_rd_addr_ready}), 64'b000);
        chk("rdf_pop_ret", 64'(s_rd_data_valid), 64'b01);
        @(negedge clk);
        m_rd_data_valid = 1'b0;
        #1 chk("rdf_resume", 64'({m_rd_addr_valid, s_rd_addr_ready}), 64'b101);
        @(negedge clk);

        // ---- write with data held off, then s1 granted ----
        do_reset();
        s_wr_addr       = {32'h300, 32'h200};
        s_wr_data       = {32'h3333, 32'h2222};
        s_wr_addr_valid = 2'b11;
        s_wr_data_valid = 2'b11;
        m_wr_addr_ready = 1'b1;
        m_wr_data_ready = 1'b0;
        #1 chk("wr_grant_cycle", 64'(wctl()), 64'b000000);
        @(negedge clk);
        #1 chk("wr0_aw", 64'(wctl()), 64'b110100);
        chk("wr0_addr", 64'(m_wr_addr), 64'h200);
        chk("wr0_data", 64'(m_wr_data), 64'h2222);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("wr0_hold", 64'(wctl()), 64'b010000);
        end
        @(negedge clk);
        m_wr_data_ready = 1'b1;
        #1 chk("wr0_w", 64'(wctl()), 64'b010001);
        @(negedge clk);
        s_wr_addr_valid = 2'b10;
        s_wr_data_valid = 2'b10;
        #1 chk("wr1_grant_cycle", 64'(wctl()), 64'b000000);
        @(negedge clk);
        #1 chk("wr1_both", 64'(wctl()), 64'b111010);
        chk("wr1_addr", 64'(m_wr_addr), 64'h300);
        chk("wr1_data", 64'(m_wr_data), 64'h3333);
        @(negedge clk);
        idle_inputs();

        // ---- write response routing ----
        m_wr_resp_valid = 1'b1;
        m_wr_resp       = 1'b1;
        #1 chk("wresp0", 64'({s_wr_resp_valid, s_wr_resp}), 64'b011);
        @(negedge clk);
        #1 chk("wresp1", 64'({s_wr_resp_valid, s_wr_resp}), 64'b101);
        @(negedge clk);
        #1 chk("wresp_drop", 64'(s_wr_resp_valid), 64'b00);
        idle_inputs();

        // ---- reset with two reads outstanding ----
        do_reset();
        s_rd_addr       = {32'hB0, 32'hA0};
        s_rd_addr_valid = 2'b11;
        m_rd_addr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst             = 1'b1;
        m_rd_data_valid = 1'b1;
        #1 chk("rst_mid_ctl", 64'(ctl()), 64'h0);
        @(negedge clk);
        rst             = 1'b0;
        s_rd_addr_valid = 2'b00;
        #1 chk("rst_late_drop", 64'(s_rd_data_valid), 64'b00);
        @(negedge clk);
        m_rd_data_valid = 1'b0;
        s_rd_addr_valid = 2'b11;
        #1 chk("rst_first_grant", 64'(m_rd_addr), 64'hA0);
        chk("rst_first_rdy", 64'(s_rd_addr_ready), 64'b01);
        @(negedge clk);

        // ---- randomized reads against an in-order owner queue ----
        do_reset();
        rlast = 1;
        rq.delete();
        for (int c = 0; c < 400; c++) begin
            rv   = 2'($urandom_range(0, 3));
            mrdy = ($urandom_range(0, 3) != 0);
            mdv  = ($urandom_range(0, 2) == 0);
            s_rd_addr       = {$urandom, $urandom};
            s_rd_addr_valid = rv;
            m_rd_addr_ready = mrdy;
            m_rd_data       = $urandom;
            m_rd_data_valid = mdv;
            sz0   = rq.size();
            g     = rv[1 - rlast] ? 1 - rlast : rlast;
            e_mv  = (rv != 2'b00) && (sz0 < int'(DEPTH));
            e_rdy = (mrdy && sz0 < int'(DEPTH)) ? 2'(1 << g) : 2'b00;
            e_ret = (mdv && sz0 > 0) ? 2'(1 << rq[0]) : 2'b00;
            #1 chk("rrand_v", 64'({m_rd_addr_valid, s_rd_data_valid}), 64'({e_mv, e_ret}));
            if (rv != 2'b00) begin
                chk("rrand_rdy", 64'(s_rd_addr_ready), 64'(e_rdy));
                chk("rrand_addr", 64'(m_rd_addr), g ? 64'(s_rd_addr[2*AW-1:AW]) : 64'(s_rd_addr[AW-1:0]));
            end
            if (e_ret != 2'b00) begin
                chk("rrand_data", 64'(s_rd_data), 64'(m_rd_data));
            end
            if (e_mv && mrdy) begin
                rq.push_back(g);
                rlast = g;
            end
            if (mdv && sz0 > 0) begin
                void'(rq.pop_front());
            end
            @(negedge clk);
        end
        idle_inputs();

        // ---- randomized writes against a transaction-level model ----
        do_reset();
        wlast = 1;
        wo    = -1;
        aw_d  = 1'b0;
        w_d   = 1'b0;
        wq.delete();
        for (int c = 0; c < 400; c++) begin
            wav  = 2'($urandom_range(0, 3));
            wdv  = 2'($urandom_range(0, 3));
            mar  = 1'($urandom_range(0, 1));
            mdr  = 1'($urandom_range(0, 1));
            rspv = ($urandom_range(0, 3) == 0);
            s_wr_addr       = {$urandom, $urandom};
            s_wr_data       = {$urandom, $urandom};
            s_wr_addr_valid = wav;
            s_wr_data_valid = wdv;
            m_wr_addr_ready = mar;
            m_wr_data_ready = mdr;
            m_wr_resp_valid = rspv;
            m_wr_resp       = 1'($urandom_range(0, 1));
            sz0 = wq.size();
            if (wo < 0) begin
                e_av = 1'b0;
                e_dv = 1'b0;
                e_ar = 2'b00;
                e_dr = 2'b00;
            end else begin
                e_av = wav[wo] && !aw_d;
                e_dv = wdv[wo] && !w_d;
                e_ar = (mar && !aw_d) ? 2'(1 << wo) : 2'b00;
                e_dr = (mdr && !w_d) ? 2'(1 << wo) : 2'b00;
            end
            e_rs = (rspv && sz0 > 0) ? 2'(1 << wq[0]) : 2'b00;
            #1 chk("wrand_ctl", 64'({wctl(), s_wr_resp_valid}), 64'({e_av, e_dv, e_ar, e_dr, e_rs}));
            if (e_av) begin
                chk("wrand_addr", 64'(m_wr_addr), wo ? 64'(s_wr_addr[2*AW-1:AW]) : 64'(s_wr_addr[AW-1:0]));
            end
            if (e_dv) begin
                chk("wrand_data", 64'(m_wr_data), wo ? 64'(s_wr_data[2*DW-1:DW]) : 64'(s_wr_data[DW-1:0]));
            end
            if (e_rs != 2'b00) begin
                chk("wrand_resp", 64'(s_wr_resp), 64'(m_wr_resp));
            end
            if (wo < 0) begin
                if (wav != 2'b00 && sz0 < int'(DEPTH)) begin
                    wo   = wav[1 - wlast] ? 1 - wlast : wlast;
                    aw_d = 1'b0;
                    w_d  = 1'b0;
                end
            end else begin
                if (e_av && mar) aw_d = 1'b1;
                if (e_dv && mdr) w_d = 1'b1;
                if (aw_d && w_d) begin
                    wq.push_back(wo);
                    wlast = wo;
                    wo    = -1;
                end
            end
            if (rspv && sz0 > 0) begin
                void'(wq.pop_front());
            end
            @(negedge clk);
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
